// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control sequencer for the multi-cycle RV32I datapath.
// Optional feature macro MC_JAL_EN: builds the jal dispatch and JAL state; otherwise jal decodes as illegal.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
`ifdef MC_JAL_EN
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`endif

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  // Registered Moore control word; the few input-gated strobes are finished combinationally.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       fetch;          // IRWrite/PCWrite follow mem_ready
    logic       pc_write;       // unconditional PC load
    logic       branch;         // PC load gated by Zero
    logic       mem_write;
    logic       reg_write;
    logic       done;           // retire unconditionally this cycle
    logic       done_on_ready;  // retire when mem_ready
    logic       decode;         // opcode legality window
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
  } ctrl_t;

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl_reg;
  logic   run_reg;

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c            = '0;
    c.alu_src_b  = 2'b10;
    c.result_src = 2'b10;
    return c;
  endfunction

  function automatic logic [2:0] alu_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7b5);
    logic [2:0] ac;
    case (f3)
      3'b000:  ac = (op[5] && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ac = ALU_SLT;
      3'b110:  ac = ALU_OR;
      3'b111:  ac = ALU_AND;
      default: ac = ALU_ADD;
    endcase
    return ac;
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ: ok = 1'b1;
`ifdef MC_JAL_EN
      OP_JAL:                                   ok = 1'b1;
`endif
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] alu_dec);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req     = 1'b1;
        c.fetch       = 1'b1;
        c.alu_src_b   = 2'b10;
        c.result_src  = 2'b10;
        c.alu_control = ALU_ADD;
      end
      DECODE: begin
        c.decode      = 1'b1;
        c.alu_src_a   = 2'b01;
        c.alu_src_b   = 2'b01;
        c.alu_control = ALU_ADD;
      end
      MEMADR: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b01;
        c.alu_control = ALU_ADD;
      end
      MEMREAD: begin
        c.mem_req     = 1'b1;
        c.adr_src     = 1'b1;
      end
      MEMWB: begin
        c.result_src  = 2'b01;
        c.reg_write   = 1'b1;
        c.done        = 1'b1;
      end
      MEMWRITE: begin
        c.mem_req       = 1'b1;
        c.adr_src       = 1'b1;
        c.mem_write     = 1'b1;
        c.done_on_ready = 1'b1;
      end
      EXECR: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b00;
        c.alu_control = alu_dec;
      end
      EXECI: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b01;
        c.alu_control = alu_dec;
      end
      ALUWB: begin
        c.reg_write   = 1'b1;
        c.done        = 1'b1;
      end
`ifdef MC_JAL_EN
      JAL: begin
        c.alu_src_a   = 2'b01;
        c.alu_src_b   = 2'b10;
        c.alu_control = ALU_ADD;
        c.pc_write    = 1'b1;
      end
`endif
      BEQ: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b00;
        c.alu_control = ALU_SUB;
        c.branch      = 1'b1;
        c.done        = 1'b1;
      end
      default: c = ctrl_idle();
    endcase
    return c;
  endfunction

  // run_reg holds the machine in FETCH for the first edge after reset so the fetch strobes start cleanly.
  always_comb begin
    state_next = state_reg;
    if (run_reg) begin
      case (state_reg)
        FETCH:    state_next = mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: state_next = MEMADR;
            OP_RTYPE:     state_next = EXECR;
            OP_ITYPE:     state_next = EXECI;
            OP_BEQ:       state_next = BEQ;
`ifdef MC_JAL_EN
            OP_JAL:       state_next = JAL;
`endif
            default:      state_next = FETCH;
          endcase
        end
        MEMADR:   state_next = (Op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
        MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
        MEMWB:    state_next = FETCH;
        EXECR:    state_next = ALUWB;
        EXECI:    state_next = ALUWB;
        ALUWB:    state_next = FETCH;
`ifdef MC_JAL_EN
        JAL:      state_next = ALUWB;
`endif
        BEQ:      state_next = FETCH;
        default:  state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg   <= 1'b0;
      state_reg <= FETCH;
      ctrl_reg  <= ctrl_idle();
    end else begin
      run_reg   <= 1'b1;
      state_reg <= state_next;
      ctrl_reg  <= ctrl_of(state_next, alu_decode(Op, funct3, funct7[5]));
    end
  end

  assign mem_req    = ctrl_reg.mem_req;
  assign AdrSrc     = ctrl_reg.adr_src;
  assign IRWrite    = ctrl_reg.fetch & mem_ready;
  assign PCWrite    = (ctrl_reg.fetch & mem_ready) | ctrl_reg.pc_write | (ctrl_reg.branch & Zero);
  assign MemWrite   = ctrl_reg.mem_write;
  assign RegWrite   = ctrl_reg.reg_write;
  assign ResultSrc  = ctrl_reg.result_src;
  assign ALUSrcA    = ctrl_reg.alu_src_a;
  assign ALUSrcB    = ctrl_reg.alu_src_b;
  assign ALUControl = ctrl_reg.alu_control;
  assign instr_done = ctrl_reg.done | (ctrl_reg.done_on_ready & mem_ready);
  assign illegal    = ctrl_reg.decode & ~op_legal(Op);

  always_comb begin
    ImmSrc = 2'b00;
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
`ifdef MC_JAL_EN
      OP_JAL:  ImmSrc = 2'b11;
`endif
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle control words and per-instruction retirement.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, instr_done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .instr_done(instr_done), .illegal(illegal)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam int         ST_RESET = 15;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  string       name_q[$];
  int          ret_q[$];
  int          cyc_cnt = 0;

  logic [18:0] act;
  assign act = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal};

  // Expected control word for one cycle, transcribed from the per-state output table.
  function automatic logic [18:0] exp_vec(input int st, input logic mr, input logic z,
                                          input logic [2:0] aluc, input logic [6:0] op,
                                          input logic ill);
    logic mreq, adr, irw, pcw, mw, rw, done, il;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] ac;
    {mreq, adr, irw, pcw, mw, rw, done, il} = 8'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
    case (st)
      0:  begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
      1:  begin sa = 2'b01; sb = 2'b01; il = ill; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  begin mreq = 1; adr = 1; end
      4:  begin rs = 2'b01; rw = 1; done = 1; end
      5:  begin mreq = 1; adr = 1; mw = 1; done = mr; end
      6:  begin sa = 2'b10; ac = aluc; end
      7:  begin rw = 1; done = 1; end
      8:  begin sa = 2'b10; sb = 2'b01; ac = aluc; end
      9:  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      10: begin sa = 2'b10; ac = 3'b001; pcw = z; done = 1; end
      default: begin sb = 2'b10; rs = 2'b10; end
    endcase
    if (op == SW)      imm = 2'b01;
    else if (op == BQ) imm = 2'b10;
`ifdef MC_JAL_EN
    else if (op == JL) imm = 2'b11;
`endif
    else               imm = 2'b00;
    return {mreq, adr, irw, pcw, mw, rw, rs, sa, sb, ac, imm, done, il};
  endfunction

  task automatic idle_cycle(input string name);
    exp_q.push_back(exp_vec(ST_RESET, mem_ready, Zero, 3'b000, Op, 1'b0));
    name_q.push_back(name);
    @(posedge clk); #1;
  endtask

  // seq: nibble i = expected state in cycle i; mr_mask bit i = mem_ready in cycle i.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic [2:0] aluc,
                           input int n, input logic [31:0] seq, input logic [7:0] mr_mask,
                           input logic ill, input logic retire);
    int st;
    Op = op; funct3 = f3; funct7 = f7; Zero = z;
    if (retire) ret_q.push_back(ill ? 256 + n : n);
    for (int i = 0; i < n; i++) begin
      st = int'(seq[4*i +: 4]);
      mem_ready = mr_mask[i];
      exp_q.push_back(exp_vec(st, mr_mask[i], z, aluc, op, ill));
      name_q.push_back($sformatf("%s.c%0d", name, i));
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compares every scheduled cycle, and every retire/illegal pulse against the retire queue.
  initial begin : monitor
    logic [18:0] e;
    string       nm;
    int          r, lat, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s ctrl got %b required %b", nm, act, e);
        end
      end
      if (!rst) begin
        cyc_cnt = 0;
      end else if (instr_done || illegal) begin
        lat = cyc_cnt + 1;
        cyc_cnt = 0;
        got = (illegal ? 256 : 0) + lat;
        checks++;
        if (ret_q.size() == 0) begin
          errors++;
          $display("FAIL retire unexpected got illegal=%0b cycles=%0d required none", illegal, lat);
        end else begin
          r = ret_q.pop_front();
          $display("retire illegal=%0b cycles=%0d", illegal, lat);
          if (got != r) begin
            errors++;
            $display("FAIL retire got illegal=%0b cycles=%0d required illegal=%0b cycles=%0d",
                     illegal, lat, r >= 256, r % 256);
          end
        end
      end else if (mem_req || cyc_cnt != 0) begin
        cyc_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b0; mem_ready = 1'b1; Zero = 1'b0; Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) idle_cycle($sformatf("reset_hold%0d", i));
    rst = 1'b1;
    idle_cycle("post_release");

    run_instr("lw",        LW, 3'b010, 7'd0,        1'b0, 3'b000, 5, 32'h0004_3210, 8'h1F, 1'b0, 1'b1);
    run_instr("sw_wait2",  SW, 3'b010, 7'd0,        1'b0, 3'b000, 6, 32'h0055_5210, 8'h27, 1'b0, 1'b1);
    run_instr("lw_wait",   LW, 3'b010, 7'd0,        1'b0, 3'b000, 7, 32'h0433_2100, 8'h6E, 1'b0, 1'b1);
    run_instr("r_sub",     RT, 3'b000, 7'b0100000,  1'b0, 3'b001, 4, 32'h0000_7610, 8'h01, 1'b0, 1'b1);
    run_instr("r_add",     RT, 3'b000, 7'b0000000,  1'b0, 3'b000, 4, 32'h0000_7610, 8'h0F, 1'b0, 1'b1);
    run_instr("r_slt",     RT, 3'b010, 7'b0100000,  1'b0, 3'b101, 4, 32'h0000_7610, 8'h0F, 1'b0, 1'b1);
    run_instr("r_or",      RT, 3'b110, 7'b0000000,  1'b0, 3'b011, 4, 32'h0000_7610, 8'h0F, 1'b0, 1'b1);
    run_instr("r_and",     RT, 3'b111, 7'b0000000,  1'b0, 3'b010, 4, 32'h0000_7610, 8'h0F, 1'b0, 1'b1);
    run_instr("r_sll",     RT, 3'b001, 7'b0100000,  1'b0, 3'b000, 4, 32'h0000_7610, 8'h0F, 1'b0, 1'b1);
    run_instr("i_addi",    IT, 3'b000, 7'b0100000,  1'b0, 3'b000, 4, 32'h0000_7810, 8'h0F, 1'b0, 1'b1);
    run_instr("i_slti",    IT, 3'b010, 7'b0000000,  1'b0, 3'b101, 4, 32'h0000_7810, 8'h0F, 1'b0, 1'b1);
    run_instr("beq_taken", BQ, 3'b000, 7'd0,        1'b1, 3'b000, 3, 32'h0000_0A10, 8'h07, 1'b0, 1'b1);
    run_instr("beq_not",   BQ, 3'b000, 7'd0,        1'b0, 3'b000, 3, 32'h0000_0A10, 8'h01, 1'b0, 1'b1);
`ifdef MC_JAL_EN
    run_instr("jal",       JL, 3'b000, 7'd0,        1'b0, 3'b000, 4, 32'h0000_7910, 8'h0F, 1'b0, 1'b1);
`else
    run_instr("jal_off",   JL, 3'b000, 7'd0,        1'b0, 3'b000, 2, 32'h0000_0010, 8'h03, 1'b1, 1'b1);
`endif
    run_instr("bad_op",    BAD, 3'b000, 7'd0,       1'b0, 3'b000, 2, 32'h0000_0010, 8'h03, 1'b1, 1'b1);

    // Abort a lw in MEMWB: RegWrite must drop with the reset and no retire may follow.
    run_instr("lw_abort",  LW, 3'b010, 7'd0,        1'b0, 3'b000, 4, 32'h0000_3210, 8'h0F, 1'b0, 1'b0);
    rst = 1'b0;
    idle_cycle("abort_reset0");
    idle_cycle("abort_reset1");
    rst = 1'b1;
    idle_cycle("abort_release");
    run_instr("lw_after",  LW, 3'b010, 7'd0,        1'b0, 3'b000, 5, 32'h0004_3210, 8'h1F, 1'b0, 1'b1);

    checks++;
    if (ret_q.size() != 0) begin
      errors++;
      $display("FAIL retire_drain got %0d pending required 0", ret_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
